// File: rtl/bram_vga_reader.sv
// Frame-buffer read side: 640x480@60 VGA timing with 2x pixel/line doubling of a
// 320x240 RGB444 image, pipelined to absorb the buffer's one-cycle read latency.
module bram_vga_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SRC_W    = 320,
    parameter int SRC_H    = 240,
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0]    H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    HS_BEG   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]    V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    V_ADV    = V_W'(2 * SRC_H - 1);
    localparam logic [V_W-1:0]    VS_BEG   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    logic [H_W-1:0]    r_h_cnt;
    logic [V_W-1:0]    r_v_cnt;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_bram_en;
    logic [ADDR_W-1:0] r_bram_addr;
    logic              r_de1, r_de2, r_hs1, r_hs2, r_vs1, r_vs2;
    logic [3:0]        r_vga_r, r_vga_g, r_vga_b;
    logic              r_vga_de, r_vga_hs, r_vga_vs;
    logic              r_frame_start;

    logic w_de0, w_hs0, w_vs0, w_h_last, w_origin;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_de0    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs0    = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign w_vs0    = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + V_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + H_W'(1);
        end
    end

    // Advancing only after odd lines makes each source row feed two output lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_base <= '0;
        end else if (w_h_last) begin
            if (r_v_cnt == V_LAST) begin
                r_row_base <= '0;
            end else if (r_v_cnt[0] && (r_v_cnt < V_ADV)) begin
                r_row_base <= r_row_base + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bram_en     <= 1'b0;
            r_bram_addr   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_bram_en     <= w_de0;
            r_frame_start <= w_origin;
            if (w_de0) begin
                r_bram_addr <= r_row_base + ADDR_W'(r_h_cnt >> 1);
            end
        end
    end

    // Stage 1 sits beside the address register, stage 2 beside the buffer's data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de1 <= 1'b0;
            r_de2 <= 1'b0;
            r_hs1 <= 1'b1;
            r_hs2 <= 1'b1;
            r_vs1 <= 1'b1;
            r_vs2 <= 1'b1;
        end else begin
            r_de1 <= w_de0;
            r_de2 <= r_de1;
            r_hs1 <= w_hs0;
            r_hs2 <= r_hs1;
            r_vs1 <= w_vs0;
            r_vs2 <= r_vs1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vga_r  <= '0;
            r_vga_g  <= '0;
            r_vga_b  <= '0;
            r_vga_de <= 1'b0;
            r_vga_hs <= 1'b1;
            r_vga_vs <= 1'b1;
        end else begin
            r_vga_r  <= r_de2 ? bram_dout[11:8] : 4'd0;
            r_vga_g  <= r_de2 ? bram_dout[7:4]  : 4'd0;
            r_vga_b  <= r_de2 ? bram_dout[3:0]  : 4'd0;
            r_vga_de <= r_de2;
            r_vga_hs <= r_hs2;
            r_vga_vs <= r_vs2;
        end
    end

    assign bram_en     = r_bram_en;
    assign bram_addr   = r_bram_addr;
    assign vga_r       = r_vga_r;
    assign vga_g       = r_vga_g;
    assign vga_b       = r_vga_b;
    assign vga_de      = r_vga_de;
    assign vga_hs      = r_vga_hs;
    assign vga_vs      = r_vga_vs;
    assign frame_start = r_frame_start;

endmodule
